// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_seq_pkg
// Shared types and helpers for the nibble-serial add/sub sequencer.
// Rev    : 1.0
// ============================================================================
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_BITS = 4;

  // Index counter width; a single-pass build still needs a 1-bit index.
  function automatic int idx_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_nibble_cin.sv
`default_nettype none
// ============================================================================
// Module : alu_nibble_cin
// Combinational 4-bit adder slice with explicit carry in and carry out.
// Rev    : 1.0
// ============================================================================
module alu_nibble_cin
  import alu_seq_pkg::*;
(
  input  logic [NIB_BITS-1:0] a_i,
  input  logic [NIB_BITS-1:0] b_i,
  input  logic                cin_i,
  output logic [NIB_BITS-1:0] sum_o,
  output logic                cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{NIB_BITS{1'b0}}, cin_i};

endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : alu_seq_ctrl
// WIDTH-bit add/sub run one nibble per cycle through a single 4-bit slice.
// Optional: ALU_SEQ_PERF_EN adds a saturating retired-op counter (op_count).
// Rev    : 1.0
// ============================================================================
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             carry,
`ifdef ALU_SEQ_PERF_EN
  output logic [15:0]      op_count,
`endif
  output logic             busy
);

  localparam int NIB = WIDTH / NIB_BITS;
  localparam int IW  = idx_width(NIB);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 cin_q, cin_d;
  logic [WIDTH-1:0]     a_q, a_d, bx_q, bx_d, result_q, result_d;
  logic                 zero_q, zero_d, ovf_q, ovf_d, carry_q, carry_d;
  logic [NIB_BITS-1:0]  nib_a, nib_b, nib_sum;
  logic                 nib_cout;

  assign nib_a = a_q[idx_q*NIB_BITS +: NIB_BITS];
  assign nib_b = bx_q[idx_q*NIB_BITS +: NIB_BITS];

  alu_nibble_cin u_nibble (
    .a_i    (nib_a),
    .b_i    (nib_b),
    .cin_i  (cin_q),
    .sum_o  (nib_sum),
    .cout_o (nib_cout)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cin_d    = cin_q;
    a_d      = a_q;
    bx_d     = bx_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    carry_d  = carry_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          bx_d    = b ^ {WIDTH{op}};
          cin_d   = op;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[idx_q*NIB_BITS +: NIB_BITS] = nib_sum;
        cin_d = nib_cout;
        idx_d = idx_q + IW'(1);
        // Flags come from result_d so the final nibble is included.
        if (idx_q == LAST_IDX) begin
          carry_d = nib_cout;
          ovf_d   = (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (result_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = ~|result_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cin_q    <= 1'b0;
      a_q      <= '0;
      bx_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cin_q    <= cin_d;
      a_q      <= a_d;
      bx_q     <= bx_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      carry_q  <= carry_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign carry     = carry_q;

`ifdef ALU_SEQ_PERF_EN
  logic [15:0] op_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_cnt_q <= '0;
    end else if (out_valid && out_ready && (op_cnt_q != 16'hFFFF)) begin
      op_cnt_q <= op_cnt_q + 16'd1;
    end
  end

  assign op_count = op_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_seq_ctrl
// Directed self-checking bench: a WIDTH=16 and a WIDTH=4 instance.
// Rev    : 1.0
// ============================================================================
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  // WIDTH=16 instance
  logic        in_valid, in_ready, op, out_valid, out_ready;
  logic [15:0] a, b, result;
  logic        zero, overflow, carry, busy;
  // WIDTH=4 instance
  logic        in_valid4, in_ready4, op4, out_valid4, out_ready4;
  logic [3:0]  a4, b4, result4;
  logic        zero4, overflow4, carry4, busy4;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0] op_count, op_count4;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow), .carry(carry),
`ifdef ALU_SEQ_PERF_EN
    .op_count(op_count),
`endif
    .busy(busy)
  );

  alu_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .op(op4), .out_valid(out_valid4), .out_ready(out_ready4),
    .result(result4), .zero(zero4), .overflow(overflow4), .carry(carry4),
`ifdef ALU_SEQ_PERF_EN
    .op_count(op_count4),
`endif
    .busy(busy4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op on the 16-bit instance, check latency, result, flags,
  // then hold back-pressure for 'hold' cycles before retiring.
  task automatic run16(input string tag, input logic [15:0] va, input logic [15:0] vb,
                       input logic vop, input logic [15:0] er, input logic ec,
                       input logic ev, input logic ez, input int hold);
    int lat;
    @(negedge clk);
    check_eq({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a = va; b = vb; op = vop; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~va; b = 16'h5A5A; op = ~vop;   // must be ignored after accept
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check_eq({tag, ".latency"}, 32'(lat), 32'd4);
    check_eq({tag, ".result"}, 32'(result), 32'(er));
    check_eq({tag, ".flags_cvz"}, {29'd0, carry, overflow, zero}, {29'd0, ec, ev, ez});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check_eq({tag, ".hold_vld_rdy"}, {30'd0, out_valid, in_ready}, 32'd2);
      check_eq({tag, ".hold_res_flags"}, {13'd0, result, carry, overflow, zero},
               {13'd0, er, ec, ev, ez});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, ".retire_rdy_vld_busy"}, {29'd0, in_ready, out_valid, busy}, 32'd4);
    check_eq({tag, ".idle_result"}, 32'(result), 32'(er));
  endtask

  task automatic run4(input string tag, input logic [3:0] va, input logic [3:0] vb,
                      input logic vop, input logic [3:0] er, input logic ec,
                      input logic ev, input logic ez);
    @(negedge clk);
    a4 = va; b4 = vb; op4 = vop; in_valid4 = 1'b1;
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, ".latency1_vld"}, 32'(out_valid4), 32'd1);
    check_eq({tag, ".result"}, 32'(result4), 32'(er));
    check_eq({tag, ".flags_cvz"}, {29'd0, carry4, overflow4, zero4}, {29'd0, ec, ev, ez});
    out_ready4 = 1'b1;
    @(posedge clk);
    #1;
    out_ready4 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; op4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset.outputs", {13'd0, result, zero, overflow, carry}, 32'd0);
    check_eq("reset.rdy_vld_busy", {29'd0, in_ready, out_valid, busy}, 32'd4);
    @(negedge clk);
    rst = 1'b0;

    run16("add_basic", 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0, 0);
    run16("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0);
    run16("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
    run16("sub_zero",  16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
    run16("sub_borrow",16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0);
    run16("sub_ovf",   16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 3);

    // Reset after two RUN cycles abandons the op.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; op = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("midrun_rst.outputs", {13'd0, result, zero, overflow, carry}, 32'd0);
    check_eq("midrun_rst.rdy_vld_busy", {29'd0, in_ready, out_valid, busy}, 32'd4);
    @(negedge clk);
    rst = 1'b0;
    run16("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 0);
`ifdef ALU_SEQ_PERF_EN
    check_eq("perf16.count", 32'(op_count), 32'd1);
`endif

    run4("w4_ovf",  4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0);
    run4("w4_wrap", 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    run4("w4_sub",  4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0);
`ifdef ALU_SEQ_PERF_EN
    check_eq("perf4.count", 32'(op_count4), 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
